// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - instruction fetch / data access sequencer owning the PC
// Walks FETCH -> DECODE -> optional MEM phase -> ADVANCE, steering the address mux and RAM strobe.
module mem_access_sequencer #(
   parameter logic [7:0] PC_RESET = 8'd0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        run,
   input  logic        opcode_ldr,
   input  logic        opcode_str,
   input  logic        branch_en,
   input  logic [7:0]  branch_target,
   input  logic [31:0] ram_data_in,
   output logic [7:0]  pc_instr_access,
   output logic        sel_add_bus,
   output logic        ram_wr_en,
   output logic [31:0] instr_reg,
   output logic        instr_valid,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      FETCH      = 3'd1,
      FETCH_WAIT = 3'd2,
      DECODE     = 3'd3,
      MEM        = 3'd4,
      MEM_WAIT   = 3'd5,
      ADVANCE    = 3'd6
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [7:0] pc;
   logic       mem_is_ldr;
   logic       mem_is_str;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         pc         <= PC_RESET;
         instr_reg  <= 32'd0;
         load_data  <= 32'd0;
         mem_is_ldr <= 1'b0;
         mem_is_str <= 1'b0;
      end else begin
         state <= state_next;
         if (state == FETCH_WAIT)
            instr_reg <= ram_data_in;
         if (state == DECODE) begin
            mem_is_ldr <= opcode_ldr;
            mem_is_str <= opcode_str & ~opcode_ldr;
         end
         if (state == MEM_WAIT)
            load_data <= ram_data_in;
         if (state == ADVANCE)
            pc <= branch_en ? branch_target : pc + 8'd1;
      end
   end

   always_comb begin
      state_next = IDLE;
      case (state)
         IDLE:       state_next = run ? FETCH : IDLE;
         FETCH:      state_next = FETCH_WAIT;
         FETCH_WAIT: state_next = DECODE;
         DECODE:     state_next = (opcode_ldr | opcode_str) ? MEM : ADVANCE;
         MEM:        state_next = mem_is_ldr ? MEM_WAIT : ADVANCE;
         MEM_WAIT:   state_next = ADVANCE;
         ADVANCE:    state_next = run ? FETCH : IDLE;
         default:    state_next = IDLE;
      endcase
   end

   // mem_is_ldr is rewritten every DECODE, so in ADVANCE it means "came from MEM_WAIT".
   assign sel_add_bus     = (state == MEM) || (state == MEM_WAIT);
   assign ram_wr_en       = (state == MEM) && mem_is_str;
   assign instr_valid     = (state == DECODE);
   assign load_valid      = (state == ADVANCE) && mem_is_ldr;
   assign pc_instr_access = pc;
   assign state_dbg       = state;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - table-driven bench for mem_access_sequencer
// Each row gives one cycle's inputs and the Moore outputs expected during that cycle.
module tb_mem_access_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        run;
   logic        opcode_ldr;
   logic        opcode_str;
   logic        branch_en;
   logic [7:0]  branch_target;
   logic [31:0] ram_data_in;
   logic [7:0]  pc_instr_access;
   logic        sel_add_bus;
   logic        ram_wr_en;
   logic [31:0] instr_reg;
   logic        instr_valid;
   logic [31:0] load_data;
   logic        load_valid;
   logic [2:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_sequencer dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .run             (run),
      .opcode_ldr      (opcode_ldr),
      .opcode_str      (opcode_str),
      .branch_en       (branch_en),
      .branch_target   (branch_target),
      .ram_data_in     (ram_data_in),
      .pc_instr_access (pc_instr_access),
      .sel_add_bus     (sel_add_bus),
      .ram_wr_en       (ram_wr_en),
      .instr_reg       (instr_reg),
      .instr_valid     (instr_valid),
      .load_data       (load_data),
      .load_valid      (load_valid),
      .state_dbg       (state_dbg)
   );

   typedef struct {
      logic        run;
      logic        ldr;
      logic        str;
      logic        br;
      logic [7:0]  tgt;
      logic [31:0] ram;
      logic [2:0]  st;
      logic [7:0]  pc;
      logic        sel;
      logic        wr;
      logic        iv;
      logic        lv;
      logic [31:0] instr;
      logic [31:0] load;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic l, input logic s, input logic b,
                      input logic [7:0] t, input logic [31:0] ram, input logic [2:0] st,
                      input logic [7:0] pc, input logic sel, input logic wr, input logic iv,
                      input logic lv, input logic [31:0] instr, input logic [31:0] load);
      vec_t v;
      v.run = r; v.ldr = l; v.str = s; v.br = b; v.tgt = t; v.ram = ram;
      v.st = st; v.pc = pc; v.sel = sel; v.wr = wr; v.iv = iv; v.lv = lv;
      v.instr = instr; v.load = load;
      vecs.push_back(v);
   endtask

   function automatic logic [80:0] pack_out(input logic [2:0] st, input logic [7:0] pc,
                                            input logic sel, input logic wr, input logic iv,
                                            input logic lv, input logic [31:0] instr,
                                            input logic [31:0] load);
      return {st, pc, sel, wr, iv, lv, instr, load};
   endfunction

   task automatic check(input string name, input logic [80:0] act, input logic [80:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string name, input vec_t v);
      check(name, pack_out(state_dbg, pc_instr_access, sel_add_bus, ram_wr_en, instr_valid,
                           load_valid, instr_reg, load_data),
                  pack_out(v.st, v.pc, v.sel, v.wr, v.iv, v.lv, v.instr, v.load));
   endtask

   task automatic drive(input vec_t v);
      run = v.run; opcode_ldr = v.ldr; opcode_str = v.str;
      branch_en = v.br; branch_target = v.tgt; ram_data_in = v.ram;
   endtask

   localparam logic [31:0] I1 = 32'h11111111, I2 = 32'h22222222, I3 = 32'h33333333;
   localparam logic [31:0] I4 = 32'h44444444, I5 = 32'h55555555, I6 = 32'h66666666;
   localparam logic [31:0] LD = 32'hDEADBEEF;

   initial begin
      vec_t rv;
      int   guard;

      //  run ldr str br tgt    ram   st  pc    sel wr iv lv instr load
      add(0, 0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 0, 0,  0);   // idle, run low
      add(1, 0, 0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0, 0, 0,  0);   // run seen in IDLE
      add(1, 0, 0, 0, 8'h00, 0,  1, 8'h00, 0, 0, 0, 0, 0,  0);
      add(1, 0, 0, 0, 8'h00, I1, 2, 8'h00, 0, 0, 0, 0, 0,  0);
      add(1, 0, 0, 0, 8'h00, 0,  3, 8'h00, 0, 0, 1, 0, I1, 0);   // plain instruction
      add(1, 0, 0, 0, 8'h00, 0,  6, 8'h00, 0, 0, 0, 0, I1, 0);
      add(1, 0, 0, 0, 8'h00, 0,  1, 8'h01, 0, 0, 0, 0, I1, 0);
      add(1, 0, 0, 0, 8'h00, I2, 2, 8'h01, 0, 0, 0, 0, I1, 0);
      add(1, 0, 1, 0, 8'h00, 0,  3, 8'h01, 0, 0, 1, 0, I2, 0);   // STR decoded
      add(1, 0, 0, 0, 8'h00, 0,  4, 8'h01, 1, 1, 0, 0, I2, 0);
      add(1, 0, 0, 0, 8'h00, 0,  6, 8'h01, 0, 0, 0, 0, I2, 0);
      add(1, 0, 0, 0, 8'h00, 0,  1, 8'h02, 0, 0, 0, 0, I2, 0);
      add(1, 1, 0, 1, 8'h99, I3, 2, 8'h02, 0, 0, 0, 0, I2, 0);   // opcode/branch ignored here
      add(1, 1, 1, 0, 8'h00, 0,  3, 8'h02, 0, 0, 1, 0, I3, 0);   // both high -> LDR
      add(1, 0, 1, 1, 8'h77, 0,  4, 8'h02, 1, 0, 0, 0, I3, 0);
      add(1, 0, 0, 0, 8'h00, LD, 5, 8'h02, 1, 0, 0, 0, I3, 0);
      add(1, 0, 0, 1, 8'hFE, 0,  6, 8'h02, 0, 0, 0, 1, I3, LD);  // load_valid + branch
      add(1, 0, 0, 0, 8'h00, 0,  1, 8'hFE, 0, 0, 0, 0, I3, LD);
      add(0, 0, 0, 1, 8'h55, I4, 2, 8'hFE, 0, 0, 0, 0, I3, LD);  // run dropped in FETCH_WAIT
      add(0, 0, 0, 0, 8'h00, 0,  3, 8'hFE, 0, 0, 1, 0, I4, LD);
      add(0, 0, 0, 0, 8'h00, 0,  6, 8'hFE, 0, 0, 0, 0, I4, LD);
      add(0, 0, 0, 0, 8'h00, 0,  0, 8'hFF, 0, 0, 0, 0, I4, LD);  // stopped, PC advanced
      add(1, 0, 0, 0, 8'h00, 0,  0, 8'hFF, 0, 0, 0, 0, I4, LD);
      add(1, 0, 0, 0, 8'h00, 0,  1, 8'hFF, 0, 0, 0, 0, I4, LD);
      add(1, 0, 0, 0, 8'h00, I5, 2, 8'hFF, 0, 0, 0, 0, I4, LD);
      add(1, 0, 0, 0, 8'h00, 0,  3, 8'hFF, 0, 0, 1, 0, I5, LD);
      add(1, 0, 0, 0, 8'h00, 0,  6, 8'hFF, 0, 0, 0, 0, I5, LD);
      add(1, 0, 0, 0, 8'h00, 0,  1, 8'h00, 0, 0, 0, 0, I5, LD);  // 255 wrapped to 0
      add(1, 0, 0, 0, 8'h00, I6, 2, 8'h00, 0, 0, 0, 0, I5, LD);
      add(1, 0, 0, 0, 8'h00, 0,  3, 8'h00, 0, 0, 1, 0, I6, LD);
      add(1, 0, 0, 1, 8'h20, 0,  6, 8'h00, 0, 0, 0, 0, I6, LD);
      add(1, 0, 0, 0, 8'h00, 0,  1, 8'h20, 0, 0, 0, 0, I6, LD);  // branched to 0x20

      reset_n = 1'b0;
      rv = vecs[0];
      drive(rv);
      repeat (2) @(negedge clk);
      #1 check_outputs("reset_state", rv);
      @(negedge clk);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         #1 check_outputs($sformatf("vec%0d", i), vecs[i]);
      end

      // mid-STR reset: run until MEM of a STR, then pulse reset between edges
      run = 1'b1; opcode_ldr = 1'b0; opcode_str = 1'b1; branch_en = 1'b0;
      guard = 0;
      while (!(state_dbg == 3'd4 && ram_wr_en) && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("str_mem_reached", {80'd0, (guard < 20)}, 81'd1);
      check("str_mem_outputs", {78'd0, sel_add_bus, ram_wr_en, instr_valid}, 81'b110);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 check("reset_wr_drop", {80'd0, ram_wr_en}, 81'd0);
      rv = vecs[0];
      check_outputs("mid_str_reset", rv);
      @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1 check_outputs("post_reset_idle", rv);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
